// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF       = 6;
  localparam int DATA_W_DEF       = 32;
  localparam int STARVE_LIMIT_DEF = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANT_D   = 3'd1,
    GRANT_I   = 3'd2,
    RELEASE_D = 3'd3,
    RELEASE_I = 3'd4
  } arb_state_e;

  // Width needed to hold 0..limit; never narrower than one bit.
  function automatic int ctr_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side buses of the arbiter; slave = arbiter, master = environment.
interface mem_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_writedata;
  logic [DATA_W-1:0] d_readdata;
  logic              d_busywait;

  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [DATA_W-1:0] i_readdata;
  logic              i_busywait;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_busywait;

  modport slave (
    input  d_read, d_write, d_address, d_writedata, i_read, i_address,
           mem_readdata, mem_busywait,
    output d_readdata, d_busywait, i_readdata, i_busywait,
           mem_read, mem_write, mem_address, mem_writedata
  );

  modport master (
    output d_read, d_write, d_address, d_writedata, i_read, i_address,
           mem_readdata, mem_busywait,
    input  d_readdata, d_busywait, i_readdata, i_busywait,
           mem_read, mem_write, mem_address, mem_writedata
  );
endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module arb_starve_ctr #(
  parameter int               WIDTH = 2,
  parameter logic [WIDTH-1:0] LIMIT = '1
)(
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_limit
);

  assign at_limit = (count == LIMIT);

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)                count <= '0;
    else if (clr)               count <= '0;
    else if (inc && !at_limit)  count <= count + 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one data memory between dcache (rd/wr) and icache (rd) with fixed dcache
// priority and bounded icache starvation. MEM_ARB_STATS_EN adds per-port grant counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
)(
  input  logic          CLK,
  input  logic          RESET,
  mem_arbiter_if.slave  bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0]   d_grant_count,
  output logic [15:0]   i_grant_count
`endif
);

  localparam int CW = ctr_width(STARVE_LIMIT);

  arb_state_e        state, state_n;
  logic              seen_busy, wr_q;
  logic [DATA_W-1:0] d_rd_q, i_rd_q;
  logic              d_req, i_req, in_grant, done, enter_d, enter_i;
  logic              d_bw, i_bw, mem_read_c, mem_write_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [CW-1:0]     starve_cnt;
  logic              starve_max;

  assign d_req    = bus.d_read | bus.d_write;
  assign i_req    = bus.i_read;
  assign in_grant = (state == GRANT_D) || (state == GRANT_I);
  // Busy must have been observed first so a memory that is slow to raise
  // busywait is not mistaken for an instant completion.
  assign done     = in_grant && seen_busy && !bus.mem_busywait;
  assign enter_d  = (state == IDLE) && (state_n == GRANT_D);
  assign enter_i  = (state == IDLE) && (state_n == GRANT_I);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    d_bw        = 1'b0;
    i_bw        = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    case (state)
      IDLE: begin
        d_bw = d_req;
        i_bw = i_req;
        if (d_req && i_req) state_n = starve_max ? GRANT_I : GRANT_D;
        else if (d_req)     state_n = GRANT_D;
        else if (i_req)     state_n = GRANT_I;
      end
      GRANT_D: begin
        // Op kind is latched at grant so a dropped request still completes.
        mem_write_c = wr_q;
        mem_read_c  = !wr_q;
        mem_addr_c  = bus.d_address;
        mem_wdata_c = bus.d_writedata;
        d_bw        = 1'b1;
        i_bw        = i_req;
        if (done) state_n = RELEASE_D;
      end
      GRANT_I: begin
        mem_read_c = 1'b1;
        mem_addr_c = bus.i_address;
        i_bw       = 1'b1;
        d_bw       = d_req;
        if (done) state_n = RELEASE_I;
      end
      RELEASE_D: begin
        i_bw    = i_req;
        state_n = IDLE;
      end
      RELEASE_I: begin
        d_bw    = d_req;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      seen_busy <= 1'b0;
      wr_q      <= 1'b0;
      d_rd_q    <= '0;
      i_rd_q    <= '0;
    end else begin
      if (done)                              seen_busy <= 1'b0;
      else if (in_grant && bus.mem_busywait) seen_busy <= 1'b1;
      if (done && state == GRANT_D) d_rd_q <= bus.mem_readdata;
      if (done && state == GRANT_I) i_rd_q <= bus.mem_readdata;
      if (enter_d) wr_q <= bus.d_write;
    end
  end

  arb_starve_ctr #(.WIDTH(CW), .LIMIT(CW'(STARVE_LIMIT))) u_starve (
    .gclk(CLK), .grst_n(RESET),
    .inc(enter_d & i_req), .clr(enter_i),
    .count(starve_cnt), .at_limit(starve_max)
  );

`ifdef MEM_ARB_STATS_EN
  logic d_sat_unused, i_sat_unused;

  arb_starve_ctr #(.WIDTH(16), .LIMIT(16'hFFFF)) u_d_stats (
    .gclk(CLK), .grst_n(RESET), .inc(enter_d), .clr(1'b0),
    .count(d_grant_count), .at_limit(d_sat_unused)
  );

  arb_starve_ctr #(.WIDTH(16), .LIMIT(16'hFFFF)) u_i_stats (
    .gclk(CLK), .grst_n(RESET), .inc(enter_i), .clr(1'b0),
    .count(i_grant_count), .at_limit(i_sat_unused)
  );
`endif

  // Reset also masks the combinational IDLE busywait path.
  assign bus.d_busywait    = d_bw & RESET;
  assign bus.i_busywait    = i_bw & RESET;
  assign bus.d_readdata    = d_rd_q;
  assign bus.i_readdata    = i_rd_q;
  assign bus.mem_read      = mem_read_c;
  assign bus.mem_write     = mem_write_c;
  assign bus.mem_address   = mem_addr_c;
  assign bus.mem_writedata = mem_wdata_c;

endmodule
